axis_chk_syn: RTL and testbench
===============================

Name: axis_chk_syn

Overview:
- Synthesizable AXI-Stream sink/checker; the receiving end of the synthetic stimulus stream.
- Accepts beats and checks each one against the expected format:
  - upper bytes equal a fixed pattern;
  - low byte is an incrementing sequence;
  - tlast on a fixed packet length;
  - tkeep all-ones;
  - tdest constant.
- Reports lock state, beat, packet and error counters, and a capture of the first bad beat.
- Placed at the far side of a datapath under test, in hardware or in sim.

Parameters:
- TDATA_NUM_BYTES, 8, tdata width in bytes; minimum 2.
- FIXED, 56'hAFE6_0000_6600, expected value of tdata[8*TDATA_NUM_BYTES-1:8]; width 8*(TDATA_NUM_BYTES-1).
- PKT_BEATS, 16, beats per packet; tlast expected on the last beat; minimum 1.
- TDEST, 0, expected tdest value (4 bits).
- LOSS_THR, 4, consecutive bad beats in LOCK that drop lock; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  enable; sink accepts beats only while high
- clr  in  1  one-cycle pulse; clears counters, sticky flag and capture, forces re-hunt
- S_AXIS_tdata  in  8*TDATA_NUM_BYTES  stream data
- S_AXIS_tdest  in  4  stream destination
- S_AXIS_tkeep  in  TDATA_NUM_BYTES  byte enables
- S_AXIS_tlast  in  1  end of packet
- S_AXIS_tvalid  in  1  source valid
- S_AXIS_tready  out  1  sink ready
- locked  out  1  checker is synchronised to the sequence
- beat_cnt  out  32  accepted beats while locked; wraps
- pkt_cnt  out  32  completed packets (tlast accepted) while locked; wraps
- err_cnt  out  16  bad beats while locked; saturates at 16'hFFFF
- err_sticky  out  1  set on first error; held until clr or rst
- err_data  out  8*TDATA_NUM_BYTES  tdata of the first bad beat
- err_flags  out  5  first-error cause: {fixed, seq, last, keep, dest}

Behaviour:
- Handshake (hs) = tvalid & tready.
- tready = registered (en & ~rst). It drops the cycle after en falls. tready never depends combinationally on tvalid.
- Reset values: every output 0; state IDLE.
- State IDLE:
  - tready low.
  - en=1 -> HUNT.
- State HUNT:
  - On hs: if fixed field and tkeep and tdest all match, seed exp_seq = tdata[7:0]+1 and the packet beat index from the beat, then -> LOCK.
  - Seeding: index = 0 if tlast=1, else 1 (mod PKT_BEATS).
  - Beats seen in HUNT are not counted.
- State LOCK:
  - Each hs compares all five fields:
    - fixed field vs FIXED;
    - tdata[7:0] vs exp_seq;
    - tlast vs (idx==PKT_BEATS-1);
    - tkeep vs all-ones;
    - tdest vs TDEST.
  - Any mismatch = bad beat.
  - exp_seq always advances to tdata[7:0]+1, mod 256. The received value is used so one drop gives one error, not a stream of errors.
  - idx advances mod PKT_BEATS and resets to 0 after any accepted tlast.
  - beat_cnt increments on every hs; pkt_cnt increments on hs with tlast.
  - A bad beat increments err_cnt and the consecutive-bad counter.
  - The first bad beat since clr sets err_sticky and captures err_data/err_flags; later errors do not overwrite them.
  - A good beat zeroes the consecutive-bad counter.
  - Consecutive-bad reaching LOSS_THR -> HUNT with locked=0; that beat is counted.
- en low in any state -> IDLE next cycle. Counters and sticky are held.
- clr has priority over an hs in the same cycle:
  - that beat is consumed but neither checked nor counted;
  - counters, sticky and capture are zeroed;
  - state -> HUNT if en, else IDLE.
- Output latency: all status outputs are registered and update the cycle after the hs. locked is high exactly while in LOCK.
- Sequence wrap 8'hFF -> 8'h00 is legal and not an error.

Optional Feature:
- AXIS_CHK_BP_EN defined:
  - tready = en_q & lfsr[0].
  - lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, stepping every cycle while en.
  - This gives pseudo-random backpressure to exercise the source's stall handling.
- Undefined: tready = en_q; no LFSR logic is present.

Decomposition:
- Package axis_syn_pkg holds:
  - state enum chk_state_t {IDLE, HUNT, LOCK};
  - err flag bit positions as localparams;
  - LFSR seed and tap constants.
- Sub-module axis_chk_lfsr: 16-bit LFSR with en and synchronous rst. Instantiated only under AXIS_CHK_BP_EN.

Test Plan:
- Common setup: TDATA_NUM_BYTES=8, FIXED=56'hAFE6_0000_6600, PKT_BEATS=4, TDEST=0.
- Clean stream: en=1, 40 beats with seq 0x00..0x27 and tlast every 4th -> locked=1 after the first beat, beat_cnt=39, pkt_cnt=9 (the HUNT seed beat is not counted), err_cnt=0.
- Sequence wrap and drop: stream crosses 0xFF->0x00, then seq 0x05 is skipped -> err_cnt=1, err_flags=5'b01000, locked stays 1.
- Lock loss: 4 consecutive beats with fixed field 56'h0 -> err_cnt=4, locked=0; next good beat relocks with err_sticky still 1.
- clr coincident with hs -> counters 0, err_sticky 0, state HUNT; the beat is not counted.
- Mid-packet en=0 then en=1 -> tready low one cycle after en falls; relock with no spurious tlast error after re-hunt.
- With AXIS_CHK_BP_EN: 1000-beat run -> tready duty roughly 50%, err_cnt=0, beat_cnt equals handshakes.

Source files
------------

// File: rtl/axis_syn_pkg.sv
// Shared types and constants for the synthetic AXI-Stream checker and its
// optional backpressure LFSR.
package axis_syn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } chk_state_t;

  // Bit positions inside err_flags: {fixed, seq, last, keep, dest}
  localparam int ERR_FIXED = 4;
  localparam int ERR_SEQ   = 3;
  localparam int ERR_LAST  = 2;
  localparam int ERR_KEEP  = 1;
  localparam int ERR_DEST  = 0;
  localparam int ERR_W     = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_chk_lfsr.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random tready backpressure.
module axis_chk_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);
  import axis_syn_pkg::*;

  logic [15:0] lfsr_reg;
  logic        feedback;

  assign feedback = ^(lfsr_reg & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else if (en) begin
      lfsr_reg <= {lfsr_reg[14:0], feedback};
    end
  end

  assign q = lfsr_reg;

endmodule

// File: rtl/axis_chk_syn.sv
// AXI-Stream sink that locks onto the synthetic stream and counts format errors.
// Optional macro AXIS_CHK_BP_EN adds LFSR-driven pseudo-random backpressure.
module axis_chk_syn #(
  parameter int                           TDATA_NUM_BYTES = 8,
  parameter logic [8*TDATA_NUM_BYTES-9:0] FIXED           = 56'hAFE6_0000_6600,
  parameter int                           PKT_BEATS       = 16,
  parameter logic [3:0]                   TDEST           = 4'd0,
  parameter int                           LOSS_THR        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic [8*TDATA_NUM_BYTES-1:0]   S_AXIS_tdata,
  input  logic [3:0]                     S_AXIS_tdest,
  input  logic [TDATA_NUM_BYTES-1:0]     S_AXIS_tkeep,
  input  logic                           S_AXIS_tlast,
  input  logic                           S_AXIS_tvalid,
  output logic                           S_AXIS_tready,
  output logic                           locked,
  output logic [31:0]                    beat_cnt,
  output logic [31:0]                    pkt_cnt,
  output logic [15:0]                    err_cnt,
  output logic                           err_sticky,
  output logic [8*TDATA_NUM_BYTES-1:0]   err_data,
  output logic [4:0]                     err_flags
);
  import axis_syn_pkg::*;

  localparam int DW = 8 * TDATA_NUM_BYTES;
  localparam int IW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam int CW = $clog2(LOSS_THR + 1);

  chk_state_t         state_reg;
  logic               en_q_reg;
  logic [7:0]         exp_seq_reg;
  logic [IW-1:0]      idx_reg;
  logic [CW-1:0]      bad_run_reg;
  logic [31:0]        beat_cnt_reg;
  logic [31:0]        pkt_cnt_reg;
  logic [15:0]        err_cnt_reg;
  logic               err_sticky_reg;
  logic [DW-1:0]      err_data_reg;
  logic [ERR_W-1:0]   err_flags_reg;

  logic                      hs;
  logic [TDATA_NUM_BYTES-2:0] fixed_byte_ok;
  logic                      fixed_ok;
  logic                      keep_ok;
  logic                      dest_ok;
  logic                      seq_ok;
  logic                      idx_last;
  logic                      last_ok;
  logic [ERR_W-1:0]          beat_flags;
  logic                      bad;
  logic [7:0]                seq_next;
  logic [IW-1:0]             idx_next;
  logic [IW-1:0]             seed_idx;
  logic [CW-1:0]             bad_run_next;
  logic                      lost;

`ifdef AXIS_CHK_BP_EN
  logic [15:0] lfsr_q;

  axis_chk_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .q   (lfsr_q)
  );

  assign S_AXIS_tready = en_q_reg & lfsr_q[0];
`else
  assign S_AXIS_tready = en_q_reg;
`endif

  assign hs = S_AXIS_tvalid & S_AXIS_tready;

  // Per-byte compare of the fixed upper field
  for (genvar gi = 0; gi < TDATA_NUM_BYTES - 1; gi++) begin : g_fixed
    assign fixed_byte_ok[gi] = (S_AXIS_tdata[8*gi+8 +: 8] == FIXED[8*gi +: 8]);
  end

  assign fixed_ok = &fixed_byte_ok;
  assign keep_ok  = &S_AXIS_tkeep;
  assign dest_ok  = (S_AXIS_tdest == TDEST);
  assign seq_ok   = (S_AXIS_tdata[7:0] == exp_seq_reg);
  assign idx_last = (idx_reg == IW'(PKT_BEATS - 1));
  assign last_ok  = (S_AXIS_tlast == idx_last);

  always_comb begin
    beat_flags            = '0;
    beat_flags[ERR_FIXED] = ~fixed_ok;
    beat_flags[ERR_SEQ]   = ~seq_ok;
    beat_flags[ERR_LAST]  = ~last_ok;
    beat_flags[ERR_KEEP]  = ~keep_ok;
    beat_flags[ERR_DEST]  = ~dest_ok;
  end

  assign bad          = |beat_flags;
  // Resync to the received value so a single drop costs a single error
  assign seq_next     = S_AXIS_tdata[7:0] + 8'd1;
  assign idx_next     = (S_AXIS_tlast || idx_last) ? '0 : idx_reg + IW'(1);
  assign seed_idx     = (S_AXIS_tlast || PKT_BEATS == 1) ? '0 : IW'(1);
  assign bad_run_next = bad_run_reg + CW'(1);
  assign lost         = bad && (bad_run_next >= CW'(LOSS_THR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      en_q_reg       <= 1'b0;
      exp_seq_reg    <= '0;
      idx_reg        <= '0;
      bad_run_reg    <= '0;
      beat_cnt_reg   <= '0;
      pkt_cnt_reg    <= '0;
      err_cnt_reg    <= '0;
      err_sticky_reg <= 1'b0;
      err_data_reg   <= '0;
      err_flags_reg  <= '0;
    end else begin
      en_q_reg <= en;
      if (clr) begin
        // A beat arriving with clr is swallowed unchecked
        beat_cnt_reg   <= '0;
        pkt_cnt_reg    <= '0;
        err_cnt_reg    <= '0;
        err_sticky_reg <= 1'b0;
        err_data_reg   <= '0;
        err_flags_reg  <= '0;
        bad_run_reg    <= '0;
        state_reg      <= en ? HUNT : IDLE;
      end else if (!en) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            bad_run_reg <= '0;
            state_reg   <= HUNT;
          end
          HUNT: begin
            if (hs && fixed_ok && keep_ok && dest_ok) begin
              exp_seq_reg <= seq_next;
              idx_reg     <= seed_idx;
              bad_run_reg <= '0;
              state_reg   <= LOCK;
            end
          end
          LOCK: begin
            if (hs) begin
              exp_seq_reg  <= seq_next;
              idx_reg      <= idx_next;
              beat_cnt_reg <= beat_cnt_reg + 32'd1;
              if (S_AXIS_tlast) begin
                pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
              end
              if (bad) begin
                if (err_cnt_reg != 16'hFFFF) begin
                  err_cnt_reg <= err_cnt_reg + 16'd1;
                end
                if (!err_sticky_reg) begin
                  err_sticky_reg <= 1'b1;
                  err_data_reg   <= S_AXIS_tdata;
                  err_flags_reg  <= beat_flags;
                end
                if (lost) begin
                  bad_run_reg <= '0;
                  state_reg   <= HUNT;
                end else begin
                  bad_run_reg <= bad_run_next;
                end
              end else begin
                bad_run_reg <= '0;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign locked     = (state_reg == LOCK);
  assign beat_cnt   = beat_cnt_reg;
  assign pkt_cnt    = pkt_cnt_reg;
  assign err_cnt    = err_cnt_reg;
  assign err_sticky = err_sticky_reg;
  assign err_data   = err_data_reg;
  assign err_flags  = err_flags_reg;

endmodule

// File: tb/tb_axis_chk_syn.sv
// Randomised bench for axis_chk_syn: a transaction-level reference model is
// compared against the DUT every cycle, plus directed literal checkpoints.
module tb_axis_chk_syn;

  localparam int          NB   = 8;
  localparam logic [55:0] FIX  = 56'hAFE6_0000_6600;
  localparam int          PKT  = 4;
  localparam int          LOSS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] tdata = '0;
  logic [3:0]  tdest = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic        locked;
  logic [31:0] beat_cnt;
  logic [31:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic        err_sticky;
  logic [63:0] err_data;
  logic [4:0]  err_flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_chk_syn #(
    .TDATA_NUM_BYTES (NB),
    .FIXED           (FIX),
    .PKT_BEATS       (PKT),
    .TDEST           (4'd0),
    .LOSS_THR        (LOSS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .clr           (clr),
    .S_AXIS_tdata  (tdata),
    .S_AXIS_tdest  (tdest),
    .S_AXIS_tkeep  (tkeep),
    .S_AXIS_tlast  (tlast),
    .S_AXIS_tvalid (tvalid),
    .S_AXIS_tready (tready),
    .locked        (locked),
    .beat_cnt      (beat_cnt),
    .pkt_cnt       (pkt_cnt),
    .err_cnt       (err_cnt),
    .err_sticky    (err_sticky),
    .err_data      (err_data),
    .err_flags     (err_flags)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: 0 = idle, 1 = hunting, 2 = locked
  int          m_mode = 0;
  bit          m_tready = 1'b0;
  int          m_exp = 0;
  int          m_pos = 0;
  logic [31:0] m_beat = '0;
  logic [31:0] m_pkt = '0;
  int          m_err = 0;
  bit          m_sticky = 1'b0;
  logic [63:0] m_edata = '0;
  logic [4:0]  m_eflags = '0;
  int          m_run = 0;

  task automatic model_step();
    bit         hs;
    int         s;
    logic [4:0] f;
    hs = tvalid && tready;
    s  = int'(tdata[7:0]);
    if (rst) begin
      m_mode = 0; m_tready = 0; m_exp = 0; m_pos = 0; m_beat = 0; m_pkt = 0;
      m_err = 0; m_sticky = 0; m_edata = 0; m_eflags = 0; m_run = 0;
    end else begin
      m_tready = en;
      if (clr) begin
        m_beat = 0; m_pkt = 0; m_err = 0; m_sticky = 0; m_edata = 0; m_eflags = 0; m_run = 0;
        m_mode = en ? 1 : 0;
      end else if (!en) begin
        m_mode = 0;
      end else if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (hs && m_mode == 1) begin
        if (tdata[63:8] == FIX && tkeep == 8'hFF && tdest == 4'd0) begin
          m_exp  = (s + 1) % 256;
          m_pos  = tlast ? 0 : (1 % PKT);
          m_run  = 0;
          m_mode = 2;
        end
      end else if (hs && m_mode == 2) begin
        f[4] = (tdata[63:8] != FIX);
        f[3] = (s != m_exp);
        f[2] = (tlast != (m_pos == PKT - 1));
        f[1] = (tkeep != 8'hFF);
        f[0] = (tdest != 4'd0);
        m_beat = m_beat + 1;
        if (tlast) m_pkt = m_pkt + 1;
        if (f != 0) begin
          if (m_err < 65535) m_err++;
          if (!m_sticky) begin
            m_sticky = 1; m_edata = tdata; m_eflags = f;
          end
          m_run++;
          if (m_run >= LOSS) begin
            m_run = 0; m_mode = 1;
          end
        end else begin
          m_run = 0;
        end
        m_exp = (s + 1) % 256;
        m_pos = tlast ? 0 : (m_pos + 1) % PKT;
      end
    end
  endtask

  initial begin : compare
    @(posedge clk);
    forever begin
      @(negedge clk);
`ifndef AXIS_CHK_BP_EN
      check("tready", 64'(tready), 64'(m_tready));
`else
      check("tready_gated", 64'(tready & ~m_tready), 64'd0);
`endif
      check("locked", 64'(locked), 64'(m_mode == 2));
      check("beat_cnt", 64'(beat_cnt), 64'(m_beat));
      check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
      check("err_cnt", 64'(err_cnt), 64'(m_err));
      check("err_sticky", 64'(err_sticky), 64'(m_sticky));
      check("err_data", err_data, m_edata);
      check("err_flags", 64'(err_flags), 64'(m_eflags));
      model_step();
    end
  end

  // Drive one beat and hold it until accepted; returns at posedge+1
  task automatic send(input logic [7:0] seq, input logic [55:0] fx, input logic [7:0] kp,
                      input bit lst, input logic [3:0] dst, input bit with_clr);
    int waited;
    bit r;
    bit done;
    waited = 0;
    done   = 0;
    tdata  = {fx, seq};
    tkeep  = kp;
    tlast  = lst;
    tdest  = dst;
    tvalid = 1'b1;
    clr    = with_clr;
    while (!done) begin
      @(negedge clk);
      r = tready;
      @(posedge clk);
      #1;
      if (r) begin
        done = 1;
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("FAIL handshake_timeout: tready low for %0d cycles, required high", waited);
          done = 1;
        end
      end
    end
    tvalid = 1'b0;
    clr    = 1'b0;
  endtask

  logic [7:0] src_seq = 8'd0;
  int         p = 0;

  task automatic good(input int n);
    for (int i = 0; i < n; i++) begin
      send(src_seq, FIX, 8'hFF, (p % PKT) == 0, 4'd0, 1'b0);
      src_seq++;
      p++;
    end
  endtask

  task automatic align_packet();
    while ((p % PKT) != 1) p++;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          r;
    logic [55:0] fx;
    logic [7:0]  kp;
    bit          lst;
    logic [3:0]  dst;

    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    check("rst_err_sticky", 64'(err_sticky), 64'd0);
    check("rst_tready", 64'(tready), 64'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Clean stream: seq 0x00..0x27, tlast on positions 0,4,8,...
    for (int s = 0; s < 40; s++) begin
      good(1);
      if (s == 0) check("lock_after_first", 64'(locked), 64'd1);
    end
    check("clean_locked", 64'(locked), 64'd1);
    check("clean_beat_cnt", 64'(beat_cnt), 64'd39);
    check("clean_pkt_cnt", 64'(pkt_cnt), 64'd9);
    check("clean_err_cnt", 64'(err_cnt), 64'd0);

    // Wrap 0xFF->0x00, then skip seq 0x05
    for (int s = 40; s < 272; s++) begin
      if (s == 261) src_seq++;
      else good(1);
    end
    check("drop_err_cnt", 64'(err_cnt), 64'd1);
    check("drop_err_flags", 64'(err_flags), 64'b01000);
    check("drop_err_data", err_data, {FIX, 8'h06});
    check("drop_locked", 64'(locked), 64'd1);

    // clr arriving together with a handshake
    send(src_seq, FIX, 8'hFF, (p % PKT) == 0, 4'd0, 1'b1);
    src_seq++;
    p++;
    check("clr_beat_cnt", 64'(beat_cnt), 64'd0);
    check("clr_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("clr_err_cnt", 64'(err_cnt), 64'd0);
    check("clr_sticky", 64'(err_sticky), 64'd0);
    check("clr_hunt", 64'(locked), 64'd0);
    align_packet();
    good(1);
    check("clr_relock", 64'(locked), 64'd1);
    check("clr_seed_uncounted", 64'(beat_cnt), 64'd0);

    // Lock loss after four bad fixed fields
    good(6);
    for (int k = 0; k < 4; k++) begin
      send(src_seq, 56'h0, 8'hFF, (p % PKT) == 0, 4'd0, 1'b0);
      src_seq++;
      p++;
      if (k == 2) check("loss_still_locked", 64'(locked), 64'd1);
    end
    check("loss_err_cnt", 64'(err_cnt), 64'd4);
    check("loss_locked", 64'(locked), 64'd0);
    check("loss_err_flags", 64'(err_flags), 64'b10000);
    check("loss_beat_cnt", 64'(beat_cnt), 64'd10);
    align_packet();
    good(1);
    check("relock_locked", 64'(locked), 64'd1);
    check("relock_sticky", 64'(err_sticky), 64'd1);
    check("relock_beat_cnt", 64'(beat_cnt), 64'd10);

    // Mid-packet enable drop
    good(6);
    en = 1'b0;
    @(negedge clk);
`ifndef AXIS_CHK_BP_EN
    check("en_fall_tready_held", 64'(tready), 64'd1);
`endif
    @(negedge clk);
    check("en_fall_tready_low", 64'(tready), 64'd0);
    check("en_fall_unlocked", 64'(locked), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    en = 1'b1;
    align_packet();
    good(12);
    check("reen_locked", 64'(locked), 64'd1);
    check("reen_err_cnt", 64'(err_cnt), 64'd4);

    // Randomised traffic with occasional corruption, enable drops and clears
    for (int i = 0; i < 1500; i++) begin
      r   = int'($urandom_range(0, 99));
      fx  = FIX;
      kp  = 8'hFF;
      lst = (p % PKT) == 0;
      dst = 4'd0;
      if (r < 4) fx = FIX ^ (56'h1 << $urandom_range(0, 55));
      else if (r < 7) src_seq = src_seq + 8'($urandom_range(1, 4));
      else if (r < 9) lst = ~lst;
      else if (r < 11) kp = 8'hFF ^ (8'h1 << $urandom_range(0, 7));
      else if (r < 13) dst = 4'($urandom_range(1, 15));
      else if (r < 15) begin
        for (int k = 0; k < 5; k++) begin
          send(src_seq, 56'h0, 8'hFF, (p % PKT) == 0, 4'd0, 1'b0);
          src_seq++;
          p++;
        end
      end else if (r < 17) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        en = 1'b1;
      end else if (r < 18) begin
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(src_seq, fx, kp, lst, dst, 1'b0);
      src_seq++;
      p++;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
